// File: rtl/lane_packer.sv
// Narrow-to-wide symbol packer: locks on a run of IDLE_SYM symbols, then packs
// RATIO symbols per word (first symbol in the MSBs) and flags words with gap fill.
module lane_packer #(
    parameter int              IN_W       = 8,
    parameter int              RATIO      = 4,
    parameter logic [IN_W-1:0] IDLE_SYM   = IN_W'(8'hBC),
    parameter int              SYNC_COUNT = 4,
    parameter bit              FILL_IDLE  = 1'b1
) (
    input  logic                  clk_4f,
    input  logic                  reset,
    input  logic [IN_W-1:0]       data_input,
    input  logic                  valid_input,
    input  logic                  realign,
    output logic [IN_W*RATIO-1:0] data_out,
    output logic                  word_strobe,
    output logic                  word_valid,
    output logic                  sincout
);

    localparam int OUT_W  = IN_W * RATIO;
    localparam int PART_W = OUT_W - IN_W;
    localparam int CNT_W  = $clog2(SYNC_COUNT + 1);
    localparam int SLOT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0]  LOCK_AT   = CNT_W'(SYNC_COUNT - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(RATIO - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    idle_cnt;
    logic [SLOT_W-1:0]   slot;
    logic [PART_W-1:0]   word_q;   // the RATIO-1 symbols collected so far
    logic [RATIO-2:0]    real_q;   // real-symbol flags matching word_q

    logic                shift_en;
    logic [IN_W-1:0]     sym;
    logic [OUT_W-1:0]    word_next;
    logic [RATIO-1:0]    real_next;

    always_comb begin
        sym       = valid_input ? data_input : IDLE_SYM;
        shift_en  = valid_input || FILL_IDLE;
        word_next = {word_q, sym};
        real_next = {real_q, valid_input};
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state       <= UNLOCKED;
            idle_cnt    <= '0;
            slot        <= '0;
            word_q      <= '0;
            real_q      <= '0;
            data_out    <= '0;
            word_strobe <= 1'b0;
            word_valid  <= 1'b0;
            sincout     <= 1'b0;
        end else begin
            word_strobe <= 1'b0;
            if (realign) begin
                // The symbol arriving with realign is dropped, even an idle.
                state    <= UNLOCKED;
                idle_cnt <= '0;
                slot     <= '0;
                word_q   <= '0;
                real_q   <= '0;
                sincout  <= 1'b0;
            end else if (state == UNLOCKED) begin
                if (valid_input) begin
                    if (data_input == IDLE_SYM) begin
                        if (idle_cnt == LOCK_AT) begin
                            state    <= LOCKED;
                            sincout  <= 1'b1;
                            idle_cnt <= '0;
                            slot     <= '0;
                            word_q   <= '0;
                            real_q   <= '0;
                        end else if (idle_cnt < LOCK_AT) begin
                            idle_cnt <= idle_cnt + CNT_W'(1);
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
            end else if (shift_en) begin
                if (slot == LAST_SLOT) begin
                    data_out    <= word_next;
                    word_valid  <= &real_next;
                    word_strobe <= 1'b1;
                    slot        <= '0;
                    word_q      <= '0;
                    real_q      <= '0;
                end else begin
                    word_q <= word_next[PART_W-1:0];
                    real_q <= real_next[RATIO-2:0];
                    slot   <= slot + SLOT_W'(1);
                end
            end
        end
    end

endmodule
